// File: rtl/uart_rx_pkg.sv
// Definitions shared by uart_tx and uart_rx: parity selection codes, FSM state
// encodings and the expected-parity helper.
package uart_rx_pkg;

   localparam logic [1:0] CHECK_NONE = 2'd0;
   localparam logic [1:0] CHECK_ODD  = 2'd1;
   localparam logic [1:0] CHECK_EVEN = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   // Expected parity bit from the running XOR of the data bits.
   function automatic logic f_parity_bit(input logic [1:0] check, input logic data_xor);
      logic bit_s;
      if (check == CHECK_ODD) begin
         bit_s = ~data_xor;
      end else begin
         bit_s = data_xor;
      end
      return bit_s;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops reset
// to P_RST_VAL so an idle-high line does not look like an edge after reset.
module uart_sync2 #(
   parameter logic P_RST_VAL = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic meta_r;

   // Two-stage resynchronization into the i_clk domain.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_r <= P_RST_VAL;
         o_q    <= P_RST_VAL;
      end else begin
         meta_r <= i_d;
         o_q    <= meta_r;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start, data (LSB first), optional parity and
// 1..2 stop bits, with a one-cycle valid pulse and registered error flags.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int P_SYSTEM_CLK      = 50_000_000,
   parameter int P_UART_BUADRATE   = 9600,
   parameter int P_UART_DATA_WIDTH = 8,
   parameter int P_UART_STOP_WIDTH = 1,
   parameter int P_UART_CHECK      = 0
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_uart_rx,
   output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
   output logic                         o_user_rx_valid,
   output logic                         o_parity_err,
   output logic                         o_frame_err
);

   localparam int          P_BIT_CYCLES = P_SYSTEM_CLK / P_UART_BUADRATE;
   localparam int          P_HALF       = P_BIT_CYCLES / 2;
   localparam logic [15:0] C_BIT_LAST   = 16'(P_BIT_CYCLES - 1);
   localparam logic [15:0] C_HALF_LAST  = 16'(P_HALF - 1);
   localparam logic [3:0]  C_DATA_LAST  = 4'(P_UART_DATA_WIDTH - 1);
   localparam logic [3:0]  C_STOP_LAST  = 4'(P_UART_STOP_WIDTH - 1);
   localparam logic [1:0]  C_CHECK      = 2'(P_UART_CHECK);

   logic                         rx_s;
   logic                         rx_prev_r;
   logic                         armed_r;
   uart_state_e                  state_r;
   logic [15:0]                  baud_cnt_r;
   logic [3:0]                   bit_cnt_r;
   logic [P_UART_DATA_WIDTH-1:0] shift_r;
   logic                         par_acc_r;
   logic                         par_err_r;
   logic                         frame_err_r;

   uart_sync2 #(
      .P_RST_VAL (1'b1)
   ) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_uart_rx),
      .o_q     (rx_s)
   );

   // Receive FSM with baud/bit counters, shifter and registered outputs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rx_prev_r       <= 1'b1;
         armed_r         <= 1'b1;
         state_r         <= ST_IDLE;
         baud_cnt_r      <= 16'd0;
         bit_cnt_r       <= 4'd0;
         shift_r         <= '0;
         par_acc_r       <= 1'b0;
         par_err_r       <= 1'b0;
         frame_err_r     <= 1'b0;
         o_user_rx_data  <= '0;
         o_user_rx_valid <= 1'b0;
         o_parity_err    <= 1'b0;
         o_frame_err     <= 1'b0;
      end else begin
         rx_prev_r       <= rx_s;
         o_user_rx_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               baud_cnt_r <= 16'd0;
               bit_cnt_r  <= 4'd0;
               // After a framing error the line must be seen high again first.
               if (rx_s) begin
                  armed_r <= 1'b1;
               end
               if (armed_r && rx_prev_r && !rx_s) begin
                  state_r     <= ST_START;
                  par_acc_r   <= 1'b0;
                  par_err_r   <= 1'b0;
                  frame_err_r <= 1'b0;
               end
            end
            ST_START: begin
               if (baud_cnt_r == C_HALF_LAST) begin
                  baud_cnt_r <= 16'd0;
                  state_r    <= rx_s ? ST_IDLE : ST_DATA;
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            ST_DATA: begin
               if (baud_cnt_r == C_BIT_LAST) begin
                  baud_cnt_r <= 16'd0;
                  shift_r    <= {rx_s, shift_r[P_UART_DATA_WIDTH-1:1]};
                  par_acc_r  <= par_acc_r ^ rx_s;
                  if (bit_cnt_r == C_DATA_LAST) begin
                     bit_cnt_r <= 4'd0;
                     state_r   <= (C_CHECK != CHECK_NONE) ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 4'd1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            ST_PARITY: begin
               if (baud_cnt_r == C_BIT_LAST) begin
                  baud_cnt_r <= 16'd0;
                  par_err_r  <= (rx_s != f_parity_bit(C_CHECK, par_acc_r));
                  state_r    <= ST_STOP;
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            ST_STOP: begin
               if (baud_cnt_r == C_BIT_LAST) begin
                  baud_cnt_r <= 16'd0;
                  if (bit_cnt_r == C_STOP_LAST) begin
                     bit_cnt_r       <= 4'd0;
                     o_user_rx_valid <= 1'b1;
                     o_user_rx_data  <= shift_r;
                     o_parity_err    <= par_err_r;
                     o_frame_err     <= frame_err_r | ~rx_s;
                     armed_r         <= ~(frame_err_r | ~rx_s);
                     state_r         <= ST_IDLE;
                  end else begin
                     frame_err_r <= frame_err_r | ~rx_s;
                     bit_cnt_r   <= bit_cnt_r + 4'd1;
                  end
               end else begin
                  baud_cnt_r <= baud_cnt_r + 16'd1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 cycles per bit: one receiver without parity
// and one with odd parity, table-driven frames plus corner-case sequences.
module tb_uart_rx;

   logic       clk;
   logic       rst_n;
   logic       line_np;
   logic       line_odd;
   logic [7:0] data_np,  data_odd;
   logic       valid_np, valid_odd;
   logic       perr_np,  perr_odd;
   logic       ferr_np,  ferr_odd;

   int n_cmp;
   int n_bad;

   logic [9:0] q_np[$];
   logic [9:0] q_odd[$];

   uart_rx #(
      .P_SYSTEM_CLK(16), .P_UART_BUADRATE(1), .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)
   ) dut_np (
      .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line_np),
      .o_user_rx_data(data_np), .o_user_rx_valid(valid_np),
      .o_parity_err(perr_np), .o_frame_err(ferr_np)
   );

   uart_rx #(
      .P_SYSTEM_CLK(16), .P_UART_BUADRATE(1), .P_UART_DATA_WIDTH(8),
      .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)
   ) dut_odd (
      .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(line_odd),
      .o_user_rx_data(data_odd), .o_user_rx_valid(valid_odd),
      .o_parity_err(perr_odd), .o_frame_err(ferr_odd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse logger: every sampled valid cycle is recorded as {ferr, perr, data}.
   always @(negedge clk) begin
      if (valid_np)  q_np.push_back({ferr_np, perr_np, data_np});
      if (valid_odd) q_odd.push_back({ferr_odd, perr_odd, data_odd});
   end

   typedef struct {
      logic       odd;
      logic [7:0] data;
      logic       par_bit;
      logic [7:0] exp_data;
      logic       exp_perr;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic odd, input logic v);
      if (odd) line_odd = v;
      else     line_np  = v;
      wait_cyc(16);
   endtask

   task automatic send_frame(input logic odd, input logic [7:0] d, input logic par_en,
                             input logic p, input logic stop);
      send_bit(odd, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(odd, d[i]);
      if (par_en) send_bit(odd, p);
      send_bit(odd, stop);
   endtask

   function automatic logic [9:0] entry(input logic odd, input int idx);
      logic [9:0] e;
      e = 10'h3ff;
      if (odd) begin
         if (idx >= 0 && idx < q_odd.size()) e = q_odd[idx];
      end else begin
         if (idx >= 0 && idx < q_np.size()) e = q_np[idx];
      end
      return e;
   endfunction

   initial begin
      int n0;
      int n1;
      n_cmp    = 0;
      n_bad    = 0;
      rst_n    = 1'b0;
      line_np  = 1'b1;
      line_odd = 1'b1;

      vecs[0] = '{1'b0, 8'h55, 1'b0, 8'h55, 1'b0};
      vecs[1] = '{1'b1, 8'hA5, 1'b1, 8'hA5, 1'b0};
      vecs[2] = '{1'b1, 8'hA5, 1'b0, 8'hA5, 1'b1};
      vecs[3] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{1'b0, 8'hFF, 1'b0, 8'hFF, 1'b0};
      vecs[5] = '{1'b1, 8'h80, 1'b0, 8'h80, 1'b0};
      vecs[6] = '{1'b1, 8'h07, 1'b1, 8'h07, 1'b1};

      wait_cyc(3);
      check("rst_data",  32'(data_np),   32'h0);
      check("rst_valid", 32'(valid_np),  32'h0);
      check("rst_perr",  32'(perr_np),   32'h0);
      check("rst_ferr",  32'(ferr_np),   32'h0);
      check("rst_valid_odd", 32'(valid_odd), 32'h0);
      rst_n = 1'b1;
      wait_cyc(20);

      // Table of well-formed frames.
      for (int v = 0; v < 7; v++) begin
         n0 = vecs[v].odd ? q_odd.size() : q_np.size();
         send_frame(vecs[v].odd, vecs[v].data, vecs[v].odd, vecs[v].par_bit, 1'b1);
         wait_cyc(20);
         n1 = vecs[v].odd ? q_odd.size() : q_np.size();
         check($sformatf("vec%0d_count", v), 32'(n1), 32'(n0 + 1));
         check($sformatf("vec%0d_data", v), 32'(entry(vecs[v].odd, n0) & 10'h0ff), 32'(vecs[v].exp_data));
         check($sformatf("vec%0d_perr", v), 32'(entry(vecs[v].odd, n0) >> 8 & 10'h001), 32'(vecs[v].exp_perr));
         check($sformatf("vec%0d_ferr", v), 32'(entry(vecs[v].odd, n0) >> 9), 32'h0);
         check($sformatf("vec%0d_hold", v),
               32'(vecs[v].odd ? data_odd : data_np), 32'(vecs[v].exp_data));
      end

      // Short low glitch must be rejected, then a normal frame still decodes.
      n0 = q_np.size();
      line_np = 1'b0;
      wait_cyc(4);
      line_np = 1'b1;
      wait_cyc(40);
      check("glitch_nopulse", 32'(q_np.size()), 32'(n0));
      send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      check("glitch_after_count", 32'(q_np.size()), 32'(n0 + 1));
      check("glitch_after_data", 32'(entry(1'b0, n0)), 32'h096);

      // Break: stop bit low and line held low.
      n0 = q_np.size();
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      line_np = 1'b0;
      wait_cyc(40);
      check("break_count", 32'(q_np.size()), 32'(n0 + 1));
      check("break_entry", 32'(entry(1'b0, n0)), 32'h23C);
      check("break_port_ferr", 32'(ferr_np), 32'h1);
      wait_cyc(40);
      check("break_no_more", 32'(q_np.size()), 32'(n0 + 1));
      line_np = 1'b1;
      wait_cyc(20);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      check("break_recover_count", 32'(q_np.size()), 32'(n0 + 2));
      check("break_recover_entry", 32'(entry(1'b0, n0 + 1)), 32'h05A);

      // Back-to-back frames with no idle gap.
      n0 = q_np.size();
      send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      check("b2b_count", 32'(q_np.size()), 32'(n0 + 2));
      check("b2b_first", 32'(entry(1'b0, n0)), 32'h001);
      check("b2b_second", 32'(entry(1'b0, n0 + 1)), 32'h0FF);

      // Reset in the middle of data bit 3 discards the frame.
      n0 = q_np.size();
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b0, 1'b0);
      line_np = 1'b0;
      wait_cyc(8);
      rst_n   = 1'b0;
      line_np = 1'b1;
      wait_cyc(4);
      check("midrst_data", 32'(data_np), 32'h0);
      check("midrst_valid", 32'(valid_np), 32'h0);
      rst_n = 1'b1;
      wait_cyc(60);
      check("midrst_nopulse", 32'(q_np.size()), 32'(n0));
      send_frame(1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
      wait_cyc(20);
      check("midrst_after_count", 32'(q_np.size()), 32'(n0 + 1));
      check("midrst_after_entry", 32'(entry(1'b0, n0)), 32'h080);
      check("midrst_after_port", 32'(data_np), 32'h80);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
